// File: rtl/phase_monitor_mc_pkg.sv
// Shared types and helpers for the multi-channel phase monitor.
// Holds the FSM state encoding, sign-select field layout and window clamp.
package phase_monitor_mc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACC,
        DONE
    } pm_state_t;

    localparam int SGN_REF = 0;
    localparam int SGN_IN  = 1;
    localparam int SGN_W   = 2;

    // Window exponent limited to [1, n_acc] so L never exceeds the accumulator range.
    function automatic logic [4:0] win_clamp(
        input logic [4:0] w,
        input int         n_acc
    );
        logic [4:0] r;
        r = w;
        if (int'(w) > n_acc) r = 5'(n_acc);
        if (r == 5'd0) r = 5'd1;
        return r;
    endfunction

endpackage

// File: rtl/pm_channel.sv
// One monitored phase: input synchronizer, sign/XOR compare and
// a disagreement accumulator with clear and enable.
module pm_channel
    import phase_monitor_mc_pkg::*;
#(
    parameter int N_ACC  = 20,
    parameter int N_SYNC = 2
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ph_in,
    input  logic             ref_s,
    input  logic [SGN_W-1:0] sign,
    input  logic             clr,
    input  logic             en,
    output logic [N_ACC-1:0] acc
);

    logic [N_SYNC-1:0] sync_q, sync_d;
    logic [N_ACC-1:0]  acc_q, acc_d;
    logic              d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = ph_in;
        d = (ref_s ^ sign[SGN_REF]) ^ (sync_q[N_SYNC-1] ^ sign[SGN_IN]);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + N_ACC'(d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync_q <= '0;
            acc_q  <= '0;
        end else begin
            sync_q <= sync_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/phase_monitor_mc.sv
// Multi-channel phase monitor: counts per-channel sign-adjusted disagreement
// with a reference phase over a 2^W-1 sample window, single-shot or continuous.
module phase_monitor_mc
    import phase_monitor_mc_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int N_ACC  = 20,
    parameter int N_SYNC = 2
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  ph_ref,
    input  logic [N_CH-1:0]       ph_in,
    input  logic [2*N_CH-1:0]     sel_sign,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic [4:0]            win_log2,
    input  logic                  cont,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  pm_valid,
    output logic [N_CH*N_ACC-1:0] pm_out
);

    localparam int PW = N_CH * N_ACC;

    pm_state_t         state_q, state_d;
    logic [N_SYNC-1:0] ref_sync_q, ref_sync_d;
    logic [N_ACC-1:0]  cnt_q, cnt_d;
    logic [N_ACC-1:0]  last_q, last_d;
    logic              cont_q, cont_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [2*N_CH-1:0] sign_q, sign_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [PW-1:0]     out_q, out_d;
    logic [PW-1:0]     acc_all;
    logic              acc_clr;
    logic              acc_en;
    logic [4:0]        w_eff;
    logic [N_ACC:0]    pow;

    assign w_eff = win_clamp(win_log2, N_ACC);
    assign pow   = (N_ACC+1)'(1) << w_eff;

    always_comb begin
        ref_sync_d    = ref_sync_q << 1;
        ref_sync_d[0] = ph_ref;
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cont_d  = cont_q;
        mask_d  = mask_q;
        sign_d  = sign_q;
        out_d   = out_q;
        valid_d = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    // Counter compares against L-1 directly.
                    last_d  = N_ACC'(pow - (N_ACC+1)'(2));
                    cont_d  = cont;
                    mask_d  = ch_mask;
                    sign_d  = sel_sign;
                    acc_clr = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == N_ACC'(N_SYNC-1)) begin
                    state_d = ACC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACC: begin
                acc_en = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == last_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_d   = acc_all;
                valid_d = 1'b1;
                if (abort || !cont_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACC;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SETTLE) || (state_d == ACC);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= IDLE;
            ref_sync_q <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            cont_q     <= 1'b0;
            mask_q     <= '0;
            sign_q     <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            ref_sync_q <= ref_sync_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            cont_q     <= cont_d;
            mask_q     <= mask_d;
            sign_q     <= sign_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pm_channel #(
            .N_ACC (N_ACC),
            .N_SYNC(N_SYNC)
        ) u_ch (
            .clk  (clk),
            .rstb (rstb),
            .ph_in(ph_in[i]),
            .ref_s(ref_sync_q[N_SYNC-1]),
            .sign (sign_q[i*SGN_W +: SGN_W]),
            .clr  (acc_clr),
            .en   (acc_en & mask_q[i]),
            .acc  (acc_all[i*N_ACC +: N_ACC])
        );
    end

    assign busy     = busy_q;
    assign pm_valid = valid_q;
    assign pm_out   = out_q;

endmodule
